spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- Parametrised SPI slave: configurable word width and SPI mode (CPOL/CPHA).
- Adds a buffered TX handshake, an RX valid strobe, multi-word frames, and underrun/frame status flags.
- SCK, SSEL and MOSI are asynchronous pins, oversampled on the system clock (clk ≥ 4× SCK).
- Sits between the external SPI master pins and the command/register logic inside the CPLD.

Parameters:
- WIDTH, 8, bits per SPI word (2..32).
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- CNT_W, 8, width of the per-frame word counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sck  in  1  SPI clock pin (async)
- ssel_n  in  1  SPI select pin, active low (async)
- mosi  in  1  SPI data in pin (async)
- miso  out  1  SPI data out
- tx_data  in  WIDTH  next word to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  TX holding buffer empty
- rx_data  out  WIDTH  last complete received word
- rx_valid  out  1  one-cycle strobe: rx_data updated
- tx_underrun  out  1  one-cycle strobe: word load found the buffer empty
- frame_start  out  1  one-cycle strobe on ssel_n assertion
- frame_done  out  1  one-cycle strobe on ssel_n deassertion
- word_cnt  out  CNT_W  words completed in current/last frame
- busy  out  1  frame active

Behaviour:
- Clock and reset:
  - Single clock clk; rst is synchronous, active-high.
  - Reset values: all outputs 0 except tx_ready = 1; miso = 0; synchroniser registers = idle values (sck = CPOL, ssel_n = 1).
- Synchronisers:
  - sck and ssel_n: 3-flop chains; edges detected on stages [2:1].
  - mosi: 2-flop chain.
  - Pin-to-detected-edge latency is 2 clk.
- Edge definitions:
  - Leading edge = rising if CPOL = 0, falling if CPOL = 1; trailing edge is the opposite.
  - Sample edge = leading if CPHA = 0, else trailing. Shift edge = the other one.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE: synced ssel_n falling edge. Pulse frame_start; bitcnt = 0; word_cnt = 0; load TX word.
  - ACTIVE -> IDLE: synced ssel_n rising edge. Pulse frame_done; a partial word is discarded with no rx_valid; miso = 0; word_cnt holds.
  - ssel_n low after reset without a falling edge: remain IDLE until a full high-to-low transition.
- Sample edge in ACTIVE:
  - Shift the synced mosi into rx_shift; bitcnt increments, wrapping at WIDTH-1 -> 0.
  - When bitcnt == WIDTH-1: rx_data <= completed word; rx_valid pulses the next cycle; word_cnt increments (wraps at 2^CNT_W).
- TX load rule (CPHA = 0):
  - Load at frame start, and on the shift edge when bitcnt == 0 and word_cnt > 0.
  - miso = MSB of the loaded word immediately.
  - On other shift edges, shift left by one.
- TX load rule (CPHA = 1):
  - Load at the leading edge when bitcnt == 0; miso presents the MSB on that edge.
  - Subsequent leading edges shift.
- Word load source:
  - Loading takes the TX holding buffer and sets tx_ready = 1 the next cycle.
  - If the buffer is empty: send all zeros and pulse tx_underrun.
- TX handshake: the buffer captures tx_data when tx_valid && tx_ready; tx_ready then drops to 0.
- Simultaneous events:
  - Load and capture in the same cycle: load takes the old buffer contents; capture refills it; tx_ready stays 0.
  - Load from an empty buffer while tx_valid is high in the same cycle: counts as underrun; the new word goes to the buffer.
- Status outputs:
  - busy = (state == ACTIVE).
  - miso is always driven (single-slave bus).
- rst asserted mid-frame: immediate return to IDLE; no frame_done; TX buffer is emptied.

Optional Feature:
- Macro: SPI_SLAVE_LSB_FIRST_EN.
- Defined: words are shifted LSB-first on both MOSI and MISO; miso presents bit 0 at load; rx_shift shifts right.
- Undefined: MSB-first, as specified above.

Decomposition:
- Package spi_pkg: mode encodings (SPI_MODE0..3 as {CPOL, CPHA}) and the state enum for IDLE/ACTIVE.
- Sub-module spi_pin_sync: the parametrised N-stage synchroniser with rise/fall edge outputs, instanced for sck and ssel_n.

Test Plan:
1. Mode 0, WIDTH = 8: preload tx 0xA5; master sends 0x3C in one frame -> miso bits 1,0,1,0,0,1,0,1; rx_data = 0x3C; one rx_valid; word_cnt = 1; frame_done pulses once.
2. Mode 3, WIDTH = 16, 3-word frame; tx_valid refilled after each tx_ready with 0x1234, 0xBEEF, 0x0F0F -> all three words appear on miso in order; rx_valid x3; no tx_underrun.
3. Underrun: no tx_valid before the frame; 2 words, mode 1 -> miso all 0; tx_underrun pulses twice; rx still correct.
4. Partial frame: deassert ssel_n after 5 bits -> no rx_valid; frame_done = 1; bitcnt restarts cleanly in the next frame (0x81 received correctly).
5. rst during bit 4 of a frame, with ssel_n kept low -> IDLE; busy = 0; tx_ready = 1; no activity until ssel_n toggles high then low.
6. SPI_SLAVE_LSB_FIRST_EN, mode 2, WIDTH = 8: tx 0x01, master sends 0x80 LSB-first -> miso first bit 1; rx_data = 0x80.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: {CPOL, CPHA} mode encodings and the frame state.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // Modes 0 and 2 sample on the leading SCK edge, modes 1 and 3 on the trailing edge.
  function automatic logic samples_on_leading(input logic [1:0] mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE2);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// N-stage synchroniser for an asynchronous pin; level and edges come from the two oldest stages.
module spi_pin_sync #(
  parameter int unsigned STAGES  = 3,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= {STAGES{RST_VAL}};
    else     r_sync <= {r_sync[STAGES-2:0], i_pin};
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  =  r_sync[STAGES-2] & ~r_sync[STAGES-1];
  assign o_fall  = ~r_sync[STAGES-2] &  r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// Oversampled SPI slave with buffered TX, RX strobe, multi-word frames and status flags.
// Define SPI_SLAVE_LSB_FIRST_EN to shift words LSB-first on MOSI and MISO.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter bit          CPOL  = 1'b0,
  parameter bit          CPHA  = 1'b0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ssel_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  localparam int unsigned    BW       = $clog2(WIDTH);
  localparam logic [1:0]     MODE     = {CPOL, CPHA};
  localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);

  spi_state_e       r_state;
  logic [1:0]       r_mosi_sync;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic [BW-1:0]    r_bitcnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic [WIDTH-2:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_tx_buf;
  logic             r_tx_ready;
  logic             r_tx_underrun;
  logic             r_frame_start;
  logic             r_frame_done;

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_lead, w_trail, w_sample, w_shift;
  logic w_active, w_start, w_do_sample, w_do_shift, w_bit0;
  logic w_load, w_capture;
  logic [WIDTH-1:0] w_load_word, w_tx_next, w_rx_next;
  logic [WIDTH-2:0] w_rx_keep;

  spi_pin_sync #(.STAGES(3), .RST_VAL(CPOL)) u_sck_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (sck),
    .o_level (w_sck_lvl),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_pin_sync #(.STAGES(3), .RST_VAL(1'b1)) u_ssel_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (ssel_n),
    .o_level (w_ss_lvl),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  assign w_lead   = CPOL ? w_sck_fall : w_sck_rise;
  assign w_trail  = CPOL ? w_sck_rise : w_sck_fall;
  assign w_sample = samples_on_leading(MODE) ? w_lead  : w_trail;
  assign w_shift  = samples_on_leading(MODE) ? w_trail : w_lead;

  assign w_active    = (r_state == ACTIVE);
  assign w_start     = (r_state == IDLE) && r_armed && w_ss_fall;
  assign w_do_sample = w_active && !w_ss_rise && w_sample;
  assign w_do_shift  = w_active && !w_ss_rise && w_shift;
  assign w_bit0      = (r_bitcnt == '0);

  // CPHA=0 preloads at select and reloads between words; CPHA=1 loads on the first leading edge of each word.
  assign w_load = CPHA ? (w_do_shift && w_bit0)
                       : (w_start || (w_do_shift && w_bit0 && (r_word_cnt != '0)));

  assign w_capture   = tx_valid && r_tx_ready;
  assign w_load_word = r_tx_ready ? '0 : r_tx_buf;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_rx_next = {r_mosi_sync[1], r_rx_shift};
  assign w_rx_keep = w_rx_next[WIDTH-1:1];
  assign w_tx_next = {1'b0, r_tx_shift[WIDTH-1:1]};
  assign miso      = r_tx_shift[0];
`else
  assign w_rx_next = {r_rx_shift, r_mosi_sync[1]};
  assign w_rx_keep = w_rx_next[WIDTH-2:0];
  assign w_tx_next = {r_tx_shift[WIDTH-2:0], 1'b0};
  assign miso      = r_tx_shift[WIDTH-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mosi_sync   <= '0;
      r_fill        <= '0;
      r_armed       <= 1'b0;
      r_bitcnt      <= '0;
      r_word_cnt    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_shift    <= '0;
      r_tx_buf      <= '0;
      r_tx_ready    <= 1'b1;
      r_tx_underrun <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_mosi_sync   <= {r_mosi_sync[0], mosi};
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;

      // Frames may only start once the synchroniser holds real pin history showing an idle bus,
      // so a select held low through reset is ignored until it goes high and low again.
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd3 && w_ss_lvl && (w_sck_lvl == CPOL)) r_armed <= 1'b1;

      if (w_capture) begin
        r_tx_buf   <= tx_data;
        r_tx_ready <= 1'b0;
      end else if (w_load) begin
        r_tx_ready <= 1'b1;
      end

      if (w_load) begin
        r_tx_shift    <= w_load_word;
        r_tx_underrun <= r_tx_ready;
      end else if (w_do_shift) begin
        r_tx_shift <= w_tx_next;
      end

      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state       <= ACTIVE;
            r_frame_start <= 1'b1;
            r_bitcnt      <= '0;
            r_word_cnt    <= '0;
          end
        end
        ACTIVE: begin
          if (w_ss_rise) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b1;
            r_bitcnt     <= '0;
            r_tx_shift   <= '0;
          end else if (w_do_sample) begin
            r_rx_shift <= w_rx_keep;
            if (r_bitcnt == LAST_BIT) begin
              r_bitcnt   <= '0;
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_word_cnt <= r_word_cnt + CNT_W'(1);
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_tx_underrun;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign word_cnt    = r_word_cnt;
  assign busy        = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: four slave instances (mode0/8, mode1/8, mode2/8, mode3/16) driven by a bit-level SPI master.
module tb_spi_slave_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sck = 4'b1100;
  logic [3:0]  ssel_n = 4'hF;
  logic [3:0]  mosi = 4'h0;
  logic [3:0]  tx_valid = 4'h0;
  logic [15:0] tx_data [4];
  logic [3:0]  miso, tx_ready, rx_valid, tx_underrun, frame_start, frame_done, busy;
  logic [15:0] rx_data [4];
  logic [7:0]  word_cnt [4];

  int vecs = 0;
  int errs = 0;
  int n_rxv [4];
  int n_und [4];
  int n_fs  [4];
  int n_fd  [4];
  logic [15:0] rx_hist [4][4];

  logic [15:0] mw [3];
  logic [15:0] sw [3];
  logic        first_bit;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned GW = (g == 3) ? 16 : 8;
    logic [GW-1:0] w_rx;
    spi_slave_core #(
      .WIDTH (GW),
      .CPOL  (g >= 2),
      .CPHA  (g == 1 || g == 3),
      .CNT_W (8)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .sck         (sck[g]),
      .ssel_n      (ssel_n[g]),
      .mosi        (mosi[g]),
      .miso        (miso[g]),
      .tx_data     (tx_data[g][GW-1:0]),
      .tx_valid    (tx_valid[g]),
      .tx_ready    (tx_ready[g]),
      .rx_data     (w_rx),
      .rx_valid    (rx_valid[g]),
      .tx_underrun (tx_underrun[g]),
      .frame_start (frame_start[g]),
      .frame_done  (frame_done[g]),
      .word_cnt    (word_cnt[g]),
      .busy        (busy[g])
    );
    assign rx_data[g] = 16'(w_rx);
  end

  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (rx_valid[g]) begin
        rx_hist[g][n_rxv[g][1:0]] <= rx_data[g];
        n_rxv[g] <= n_rxv[g] + 1;
      end
      if (tx_underrun[g]) n_und[g] <= n_und[g] + 1;
      if (frame_start[g]) n_fs[g] <= n_fs[g] + 1;
      if (frame_done[g])  n_fd[g] <= n_fd[g] + 1;
    end
  end

  // Present one word to the TX buffer once it reports empty.
  task automatic push(input int g, input logic [15:0] d);
    bit ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(posedge clk); #2;
      if (tx_ready[g]) begin
        tx_data[g]  = d;
        tx_valid[g] = 1'b1;
        @(posedge clk); #2;
        tx_valid[g] = 1'b0;
        ok = 1'b1;
      end
    end
    vecs++;
    if (ok !== 1'b1) begin
      errs++;
      $display("FAIL push_dut%0d: tx_ready got 0, expected 1 within 1000 cycles", g);
    end
  endtask

  // Master: select, clock nbits from mw[], record miso into sw[], deselect. SCK half-period = 4 clk.
  task automatic spi_frame(input int g, input int nbits);
    int   w    = (g == 3) ? 16 : 8;
    logic cpol = (g >= 2);
    logic cpha = (g == 1 || g == 3);
    for (int k = 0; k < 3; k++) sw[k] = '1;
    @(posedge clk); #2;
    ssel_n[g] = 1'b0;
    #80;
    for (int b = 0; b < nbits; b++) begin
      int wi;
      int idx;
      wi = b / w;
`ifdef SPI_SLAVE_LSB_FIRST_EN
      idx = b % w;
`else
      idx = w - 1 - (b % w);
`endif
      if (!cpha) begin
        mosi[g] = mw[wi][idx];
        #40;
        sw[wi][idx] = miso[g];
        if (b == 0) first_bit = miso[g];
        sck[g] = ~cpol;
        #40;
        sck[g] = cpol;
      end else begin
        sck[g]  = ~cpol;
        mosi[g] = mw[wi][idx];
        #40;
        sw[wi][idx] = miso[g];
        if (b == 0) first_bit = miso[g];
        sck[g] = cpol;
        #40;
      end
    end
    #40;
    ssel_n[g] = 1'b1;
    #80;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 4; g++) begin
      vecs++;
      if ({busy[g], miso[g], rx_valid[g], tx_underrun[g], frame_start[g], frame_done[g], tx_ready[g]} !== 7'b0000001) begin
        errs++;
        $display("FAIL reset_flags_dut%0d: got %b, expected 0000001", g,
                 {busy[g], miso[g], rx_valid[g], tx_underrun[g], frame_start[g], frame_done[g], tx_ready[g]});
      end
      vecs++;
      if (rx_data[g] !== 16'h0) begin
        errs++;
        $display("FAIL reset_rx_data_dut%0d: got %h, expected 0000", g, rx_data[g]);
      end
      vecs++;
      if (word_cnt[g] !== 8'h0) begin
        errs++;
        $display("FAIL reset_word_cnt_dut%0d: got %0d, expected 0", g, word_cnt[g]);
      end
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_mode0_single();
    int b_rxv = n_rxv[0];
    int b_fd  = n_fd[0];
    int b_fs  = n_fs[0];
    push(0, 16'h00A5);
    mw[0] = 16'h003C;
    spi_frame(0, 8);
    vecs++;
    if (sw[0][7:0] !== 8'hA5) begin errs++; $display("FAIL m0_miso: got %h, expected a5", sw[0][7:0]); end
    vecs++;
    if (rx_data[0] !== 16'h003C) begin errs++; $display("FAIL m0_rx_data: got %h, expected 003c", rx_data[0]); end
    vecs++;
    if (n_rxv[0] - b_rxv !== 1) begin errs++; $display("FAIL m0_rx_valid_count: got %0d, expected 1", n_rxv[0] - b_rxv); end
    vecs++;
    if (word_cnt[0] !== 8'd1) begin errs++; $display("FAIL m0_word_cnt: got %0d, expected 1", word_cnt[0]); end
    vecs++;
    if (n_fd[0] - b_fd !== 1) begin errs++; $display("FAIL m0_frame_done: got %0d, expected 1", n_fd[0] - b_fd); end
    vecs++;
    if (n_fs[0] - b_fs !== 1) begin errs++; $display("FAIL m0_frame_start: got %0d, expected 1", n_fs[0] - b_fs); end
    vecs++;
    if (busy[0] !== 1'b0) begin errs++; $display("FAIL m0_busy_after: got %b, expected 0", busy[0]); end
  endtask

  task automatic test_mode3_multiword();
    int b_rxv = n_rxv[3];
    int b_und = n_und[3];
    logic [15:0] exp_tx [3];
    exp_tx[0] = 16'h1234; exp_tx[1] = 16'hBEEF; exp_tx[2] = 16'h0F0F;
    mw[0] = 16'hC3A5; mw[1] = 16'h5A0F; mw[2] = 16'h9669;
    push(3, exp_tx[0]);
    fork
      spi_frame(3, 48);
      begin
        push(3, exp_tx[1]);
        push(3, exp_tx[2]);
      end
    join
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (sw[k] !== exp_tx[k]) begin errs++; $display("FAIL m3_miso_word%0d: got %h, expected %h", k, sw[k], exp_tx[k]); end
      vecs++;
      if (rx_hist[3][(b_rxv + k) % 4] !== mw[k]) begin
        errs++;
        $display("FAIL m3_rx_word%0d: got %h, expected %h", k, rx_hist[3][(b_rxv + k) % 4], mw[k]);
      end
    end
    vecs++;
    if (n_rxv[3] - b_rxv !== 3) begin errs++; $display("FAIL m3_rx_valid_count: got %0d, expected 3", n_rxv[3] - b_rxv); end
    vecs++;
    if (n_und[3] - b_und !== 0) begin errs++; $display("FAIL m3_underrun: got %0d, expected 0", n_und[3] - b_und); end
    vecs++;
    if (word_cnt[3] !== 8'd3) begin errs++; $display("FAIL m3_word_cnt: got %0d, expected 3", word_cnt[3]); end
  endtask

  task automatic test_underrun();
    int b_rxv = n_rxv[1];
    int b_und = n_und[1];
    mw[0] = 16'h0096; mw[1] = 16'h004B;
    spi_frame(1, 16);
    vecs++;
    if ({sw[0][7:0], sw[1][7:0]} !== 16'h0000) begin
      errs++;
      $display("FAIL ur_miso: got %h, expected 0000", {sw[0][7:0], sw[1][7:0]});
    end
    vecs++;
    if (n_und[1] - b_und !== 2) begin errs++; $display("FAIL ur_underrun_count: got %0d, expected 2", n_und[1] - b_und); end
    vecs++;
    if (n_rxv[1] - b_rxv !== 2) begin errs++; $display("FAIL ur_rx_valid_count: got %0d, expected 2", n_rxv[1] - b_rxv); end
    vecs++;
    if ({rx_hist[1][b_rxv % 4], rx_hist[1][(b_rxv + 1) % 4]} !== {16'h0096, 16'h004B}) begin
      errs++;
      $display("FAIL ur_rx_words: got %h %h, expected 0096 004b", rx_hist[1][b_rxv % 4], rx_hist[1][(b_rxv + 1) % 4]);
    end
  endtask

  task automatic test_partial_frame();
    int b_rxv = n_rxv[0];
    int b_fd  = n_fd[0];
    mw[0] = 16'h00FF;
    spi_frame(0, 5);
    vecs++;
    if (n_rxv[0] - b_rxv !== 0) begin errs++; $display("FAIL part_rx_valid: got %0d, expected 0", n_rxv[0] - b_rxv); end
    vecs++;
    if (n_fd[0] - b_fd !== 1) begin errs++; $display("FAIL part_frame_done: got %0d, expected 1", n_fd[0] - b_fd); end
    vecs++;
    if (word_cnt[0] !== 8'd0) begin errs++; $display("FAIL part_word_cnt: got %0d, expected 0", word_cnt[0]); end
    mw[0] = 16'h0081;
    spi_frame(0, 8);
    vecs++;
    if (rx_data[0] !== 16'h0081) begin errs++; $display("FAIL part_next_rx: got %h, expected 0081", rx_data[0]); end
    vecs++;
    if (n_rxv[0] - b_rxv !== 1) begin errs++; $display("FAIL part_next_rx_valid: got %0d, expected 1", n_rxv[0] - b_rxv); end
  endtask

  task automatic test_reset_mid_frame();
    int b_rxv;
    int b_fs;
    int b_fd;
    push(0, 16'h0055);
    @(posedge clk); #2;
    ssel_n[0] = 1'b0;
    #80;
    push(0, 16'h0066);
    for (int b = 0; b < 4; b++) begin
      mosi[0] = b[0];
      #40; sck[0] = 1'b1;
      #40; sck[0] = 1'b0;
    end
    vecs++;
    if ({busy[0], tx_ready[0]} !== 2'b10) begin errs++; $display("FAIL rstmid_before: busy/tx_ready got %b, expected 10", {busy[0], tx_ready[0]}); end
    mosi[0] = 1'b1;
    #40; sck[0] = 1'b1;
    @(posedge clk); #2;
    b_rxv = n_rxv[0]; b_fs = n_fs[0]; b_fd = n_fd[0];
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    sck[0] = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vecs++;
    if ({busy[0], tx_ready[0]} !== 2'b01) begin errs++; $display("FAIL rstmid_after: busy/tx_ready got %b, expected 01", {busy[0], tx_ready[0]}); end
    for (int b = 0; b < 8; b++) begin
      mosi[0] = 1'b1;
      #40; sck[0] = 1'b1;
      #40; sck[0] = 1'b0;
    end
    #80;
    vecs++;
    if ({n_fs[0] - b_fs, n_rxv[0] - b_rxv, n_fd[0] - b_fd} !== {32'd0, 32'd0, 32'd0}) begin
      errs++;
      $display("FAIL rstmid_quiet: fs/rxv/fd got %0d/%0d/%0d, expected 0/0/0", n_fs[0] - b_fs, n_rxv[0] - b_rxv, n_fd[0] - b_fd);
    end
    vecs++;
    if (busy[0] !== 1'b0) begin errs++; $display("FAIL rstmid_busy_held: got %b, expected 0", busy[0]); end
    ssel_n[0] = 1'b1;
    #80;
    mw[0] = 16'h00C3;
    spi_frame(0, 8);
    vecs++;
    if (rx_data[0] !== 16'h00C3) begin errs++; $display("FAIL rstmid_next_rx: got %h, expected 00c3", rx_data[0]); end
    vecs++;
    if (n_fs[0] - b_fs !== 1) begin errs++; $display("FAIL rstmid_next_start: got %0d, expected 1", n_fs[0] - b_fs); end
  endtask

  task automatic test_mode2_bit_order();
    logic exp_first;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    push(2, 16'h0001);
    mw[0] = 16'h0080;
    spi_frame(2, 8);
    vecs++;
    if (first_bit !== exp_first) begin errs++; $display("FAIL m2_first_miso_bit: got %b, expected %b", first_bit, exp_first); end
    vecs++;
    if (sw[0][7:0] !== 8'h01) begin errs++; $display("FAIL m2_miso_word: got %h, expected 01", sw[0][7:0]); end
    vecs++;
    if (rx_data[2] !== 16'h0080) begin errs++; $display("FAIL m2_rx_data: got %h, expected 0080", rx_data[2]); end
  endtask

  initial begin
    for (int g = 0; g < 4; g++) tx_data[g] = '0;
    test_reset();
    test_mode0_single();
    test_mode3_multiword();
    test_underrun();
    test_partial_frame();
    test_reset_mid_frame();
    test_mode2_bit_order();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before the test sequence completed");
    $fatal(1);
  end

endmodule
